bcd_serial_adder: RTL and testbench

//   Parametrised, digit-serial BCD adder/subtractor for multi-digit packed-BCD operands.

---
 rtl/bcd_serial_adder_pkg.sv | 14 +
 rtl/bcd_serial_adder_digit_adder.sv | 31 +++
 rtl/bcd_serial_adder.sv | 133 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants and FSM encoding for the digit-serial BCD adder.
package bcd_serial_adder_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_MAX     = 9;
   localparam int BCD_CORR    = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_serial_adder_digit_adder.sv
// Single-digit BCD adder with optional 9's complement of b and decimal correction.
module bcd_digit_adder
   import bcd_serial_adder_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a,
   input  logic [BCD_DIGIT_W-1:0] b,
   input  logic                   cin,
   input  logic                   sub,
   output logic [BCD_DIGIT_W-1:0] s,
   output logic                   cout,
   output logic                   bad
);

   logic [BCD_DIGIT_W-1:0] b_eff;
   logic [BCD_DIGIT_W:0]   raw;

   // Complement b for subtract, binary add, then apply +6 correction on decimal overflow.
   always_comb begin
      b_eff = sub ? (BCD_DIGIT_W'(BCD_MAX) - b) : b;
      raw   = {1'b0, a} + {1'b0, b_eff} + {{BCD_DIGIT_W{1'b0}}, cin};
      bad   = (a > BCD_DIGIT_W'(BCD_MAX)) || (b > BCD_DIGIT_W'(BCD_MAX));
      if (raw > (BCD_DIGIT_W + 1)'(BCD_MAX)) begin
         s    = BCD_DIGIT_W'(raw + (BCD_DIGIT_W + 1)'(BCD_CORR));
         cout = 1'b1;
      end else begin
         s    = raw[BCD_DIGIT_W-1:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, LS digit first, valid/ready on both sides.
//
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready=1
//   S_BUSY | one digit per cycle through the shared digit adder
//   S_DONE | result held on outputs until out_ready
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] in_x,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] in_y,
   input  logic                          in_cin,
   input  logic                          in_sub,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_sum,
   output logic                          out_cout,
   output logic                          out_err
);

   localparam int W     = BCD_DIGIT_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t state_q, state_nx;

   logic [W-1:0]     x_q, y_q, sum_q, sum_nx;
   logic             sub_q, carry_q, err_q, err_nx;
   logic [IDX_W-1:0] idx_q;
   logic             last_digit;

   logic [W-1:0]     out_sum_q;
   logic             out_cout_q, out_err_q;

   logic [BCD_DIGIT_W-1:0] dig_s;
   logic                   dig_cout, dig_bad;

   // Operands are shifted right each digit, so the shared adder always sees the low digit.
   bcd_digit_adder u_digit (
      .a    (x_q[BCD_DIGIT_W-1:0]),
      .b    (y_q[BCD_DIGIT_W-1:0]),
      .cin  (carry_q),
      .sub  (sub_q),
      .s    (dig_s),
      .cout (dig_cout),
      .bad  (dig_bad)
   );

   // New digit enters at the top of the sum register; after DIGITS shifts all are in place.
   always_comb begin
      sum_nx     = (sum_q >> BCD_DIGIT_W) | (W'(dig_s) << (W - BCD_DIGIT_W));
      err_nx     = err_q | dig_bad;
      last_digit = (idx_q == IDX_W'(DIGITS - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)   state_nx = S_BUSY;
         S_BUSY:  if (last_digit) state_nx = S_DONE;
         S_DONE:  if (out_ready)  state_nx = S_IDLE;
         default:                 state_nx = S_IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state register.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   // Operand capture, per-digit shifting, and result latch on the final digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         sum_q      <= '0;
         sub_q      <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         out_sum_q  <= '0;
         out_cout_q <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q     <= in_x;
                  y_q     <= in_y;
                  sub_q   <= in_sub;
                  carry_q <= in_cin;
                  err_q   <= 1'b0;
                  sum_q   <= '0;
                  idx_q   <= '0;
               end
            end
            S_BUSY: begin
               x_q     <= x_q >> BCD_DIGIT_W;
               y_q     <= y_q >> BCD_DIGIT_W;
               sum_q   <= sum_nx;
               carry_q <= dig_cout;
               err_q   <= err_nx;
               idx_q   <= idx_q + IDX_W'(1);
               if (last_digit) begin
                  // A bad input digit poisons the whole result.
                  out_sum_q  <= err_nx ? '0 : sum_nx;
                  out_cout_q <= err_nx ? 1'b0 : dig_cout;
                  out_err_q  <= err_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sum  = out_sum_q;
   assign out_cout = out_cout_q;
   assign out_err  = out_err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4 and DIGITS=1 builds).
module tb_bcd_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [15:0] in_x, in_y, out_sum;
   logic        out_valid, out_ready, out_cout, out_err;

   logic        in_valid_1, in_ready_1, in_cin_1, in_sub_1;
   logic [3:0]  in_x_1, in_y_1, out_sum_1;
   logic        out_valid_1, out_ready_1, out_cout_1, out_err_1;

   int n_tests = 0;
   int n_fail  = 0;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err)
   );

   bcd_serial_adder #(.DIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_1), .in_ready(in_ready_1),
      .in_x(in_x_1), .in_y(in_y_1), .in_cin(in_cin_1), .in_sub(in_sub_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1),
      .out_sum(out_sum_1), .out_cout(out_cout_1), .out_err(out_err_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation, then count edges until out_valid (bounded).
   task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                        input logic cin, input logic sub, output int lat);
      in_x = x; in_y = y; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_x = 16'h0; in_y = 16'h0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0 ||
          out_cout !== 1'b0 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b vld=%b sum=%h cout=%b err=%b, want 1 0 0000 0 0",
                  in_ready, out_valid, out_sum, out_cout, out_err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      int lat;
      do_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
      n_tests++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL add latency: got %0d edges, want 4", lat);
      end
      n_tests++;
      if (out_sum !== 16'h6912 || out_cout !== 1'b0 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL add 1234+5678: sum=%h cout=%b err=%b, want 6912 0 0", out_sum, out_cout, out_err);
      end
      release_result();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL add release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_carry();
      int lat;
      do_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
      n_tests++;
      if (out_sum !== 16'h0000 || out_cout !== 1'b1 || lat !== 4) begin
         n_fail++;
         $display("FAIL carry 9999+0001: sum=%h cout=%b lat=%0d, want 0000 1 4", out_sum, out_cout, lat);
      end
      release_result();
      do_op(16'h9999, 16'h9999, 1'b1, 1'b0, lat);
      n_tests++;
      if (out_sum !== 16'h9999 || out_cout !== 1'b1) begin
         n_fail++;
         $display("FAIL carry 9999+9999+1: sum=%h cout=%b, want 9999 1", out_sum, out_cout);
      end
      release_result();
   endtask

   task automatic test_sub();
      int lat;
      do_op(16'h5000, 16'h1234, 1'b1, 1'b1, lat);
      n_tests++;
      if (out_sum !== 16'h3766 || out_cout !== 1'b1) begin
         n_fail++;
         $display("FAIL sub 5000-1234: sum=%h cout=%b, want 3766 1", out_sum, out_cout);
      end
      release_result();
      do_op(16'h1234, 16'h5000, 1'b1, 1'b1, lat);
      n_tests++;
      if (out_sum !== 16'h6234 || out_cout !== 1'b0) begin
         n_fail++;
         $display("FAIL sub 1234-5000: sum=%h cout=%b, want 6234 0", out_sum, out_cout);
      end
      release_result();
   endtask

   task automatic test_err();
      int lat;
      do_op(16'h12A4, 16'h0000, 1'b0, 1'b0, lat);
      n_tests++;
      if (out_err !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b0) begin
         n_fail++;
         $display("FAIL err x=12A4: err=%b sum=%h cout=%b, want 1 0000 0", out_err, out_sum, out_cout);
      end
      release_result();
      do_op(16'h1111, 16'h1111, 1'b0, 1'b0, lat);
      n_tests++;
      if (out_err !== 1'b0 || out_sum !== 16'h2222) begin
         n_fail++;
         $display("FAIL err clear: err=%b sum=%h, want 0 2222", out_err, out_sum);
      end
      release_result();
      do_op(16'h0001, 16'hF000, 1'b0, 1'b0, lat);
      n_tests++;
      if (out_err !== 1'b1 || out_sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL err y=F000: err=%b sum=%h, want 1 0000", out_err, out_sum);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad_cycles;
      do_op(16'h0045, 16'h0038, 1'b0, 1'b0, lat);
      bad_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_x = 16'h1111; in_y = 16'h1111;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h0083 ||
             out_cout !== 1'b0 || out_err !== 1'b0)
            bad_cycles++;
      end
      n_tests++;
      if (bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL backpressure hold: %0d unstable cycles (sum=%h vld=%b rdy=%b), want 0 with sum 0083",
                  bad_cycles, out_sum, out_valid, in_ready);
      end
      release_result();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL backpressure release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
      end
      repeat (6) @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ignored in_valid: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      // Leave a nonzero result latched, then abort a new op mid-flight.
      do_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat);
      release_result();
      in_x = 16'h4444; in_y = 16'h4444; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0 ||
          out_err !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset mid-op: vld=%b sum=%h cout=%b err=%b rdy=%b, want 0 0000 0 0 1",
                  out_valid, out_sum, out_cout, out_err, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
      n_tests++;
      if (out_sum !== 16'h0002 || out_cout !== 1'b0 || lat !== 4) begin
         n_fail++;
         $display("FAIL after reset 0001+0001: sum=%h cout=%b lat=%0d, want 0002 0 4", out_sum, out_cout, lat);
      end
      release_result();
   endtask

   task automatic test_digits1();
      int lat;
      in_x_1 = 4'h7; in_y_1 = 4'h5; in_cin_1 = 1'b0; in_sub_1 = 1'b0; in_valid_1 = 1'b1;
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      lat = 0;
      while (!out_valid_1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      n_tests++;
      if (out_sum_1 !== 4'h2 || out_cout_1 !== 1'b1 || out_err_1 !== 1'b0 || lat !== 1) begin
         n_fail++;
         $display("FAIL digits1 7+5: sum=%h cout=%b err=%b lat=%0d, want 2 1 0 1",
                  out_sum_1, out_cout_1, out_err_1, lat);
      end
      out_ready_1 = 1'b1;
      @(posedge clk); #1;
      out_ready_1 = 1'b0;
      n_tests++;
      if (in_ready_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
         n_fail++; $display("FAIL digits1 release: rdy=%b vld=%b, want 1 0", in_ready_1, out_valid_1);
      end
   endtask

   initial begin
      in_valid = 1'b0; in_x = 16'h0; in_y = 16'h0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
      in_valid_1 = 1'b0; in_x_1 = 4'h0; in_y_1 = 4'h0; in_cin_1 = 1'b0; in_sub_1 = 1'b0;
      out_ready_1 = 1'b0;
      test_reset();
      test_add();
      test_carry();
      test_sub();
      test_err();
      test_backpressure();
      test_reset_mid();
      test_digits1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
